// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared types and helpers for the MC14500B reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    // Sequencer states: wait for internal reset, hold all, staggered release, idle
    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HOLD = 2'd1,
        REL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Depth of the reset-deassertion synchroniser
    localparam int SYNC_STAGES = 2;

    // Larger of two integers, used to size the shared hold/stagger counter
    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer_if
// Description : Soft-reset request and per-channel reset status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface reset_sequencer_if #(
    parameter int NUM_CH = 2
) ();

    logic              soft_req;
    logic [NUM_CH-1:0] soft_mask;
    logic [NUM_CH-1:0] ch_reset;
    logic              seq_busy;
    logic              seq_done;

    // Requester side: raises soft resets and observes the channel resets
    modport master (
        output soft_req,
        output soft_mask,
        input  ch_reset,
        input  seq_busy,
        input  seq_done
    );

    // Sequencer side
    modport slave (
        input  soft_req,
        input  soft_mask,
        output ch_reset,
        output seq_busy,
        output seq_done
    );

endinterface
`default_nettype wire

// File: rtl/reset_sequencer_sync.sv
`default_nettype none
// ============================================================================
// Module      : reset_sync
// Description : Async-assert / sync-deassert reset synchroniser.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sync
    import reset_seq_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset,
    output logic      rst_int
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Set all stages immediately on reset, shift zeros in once reset is gone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_int = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Power-on / soft reset sequencer. All channel resets assert
//               together, then release in ascending order after a hold
//               period with a fixed stagger between channels.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int HOLD_CYC = 2,
    parameter int STAGGER  = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    reset_sequencer_if.slave   bus
);

    localparam int CNT_W = $clog2(max(HOLD_CYC, STAGGER) + 1);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] c_STAG_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_LAST  = IDX_W'(NUM_CH - 1);

    logic              w_rst_int;

    state_t            r_state,  w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx,    w_idx_nxt;
    logic [IDX_W-1:0]  w_idx_inc;
    logic [NUM_CH-1:0] r_ch,     w_ch_nxt;
    logic              r_busy,   w_busy_nxt;
    logic              r_done,   w_done_nxt;

    reset_sync u_reset_sync (
        .clk     (clk),
        .reset   (reset),
        .rst_int (w_rst_int)
    );

    // State and output registers; reset values apply as soon as reset rises
    always_ff @(posedge clk or posedge w_rst_int) begin
        if (w_rst_int) begin
            r_state <= SYNC;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ch    <= '1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_ch    <= w_ch_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic. Masked channels still consume their stagger slot,
    // so release timing never depends on the soft-reset mask.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_ch_nxt    = r_ch;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_idx_inc   = r_idx + c_IDX_ONE;

        case (r_state)
            SYNC: begin
                w_state_nxt = HOLD;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
            HOLD: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_ch_nxt[0] = 1'b0;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    if (NUM_CH == 1) begin
                        w_state_nxt = DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = REL;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            REL: begin
                if (r_cnt == c_STAG_LAST) begin
                    w_ch_nxt[w_idx_inc] = 1'b0;
                    w_idx_nxt           = w_idx_inc;
                    w_cnt_nxt           = '0;
                    if (w_idx_inc == c_IDX_LAST) begin
                        w_state_nxt = DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            DONE: begin
                if (bus.soft_req) begin
                    w_ch_nxt    = ~bus.soft_mask;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = SYNC;
            end
        endcase
    end

    assign bus.ch_reset = r_ch;
    assign bus.seq_busy = r_busy;
    assign bus.seq_done = r_done;

endmodule
`default_nettype wire
